// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS IF stage + IF/ID register, req/ack imem fetch with delay-slot redirects
// Ports: clk, rst_n (async, active low); stall, jump_reg/jump_target/jump_branch, jr_pc,
//   branch_imm from decode; imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
//   pc_id/instr_id/valid_id to decode; perf_fetch_count/perf_wait_count are live only when
//   FETCH_PERF_EN is defined, otherwise tied to 0.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  input  logic [31:0] branch_imm,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        valid_id,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_wait_count
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;
  state_e state_q, state_d;
  logic req_q, req_d, valid_q, valid_d, pend_v_q, pend_v_d;
  logic [31:0] addr_q, addr_d, pc_q, pc_d, instr_q, instr_d, hold_q, hold_d, pend_q, pend_d;
  logic id_accept, take, load;
  logic [31:0] pc4, target, next_addr;
  assign id_accept = ~valid_q | ~stall;
  assign take = valid_q & ~stall & (jump_reg | jump_target | jump_branch);
  assign pc4 = pc_q + 32'd4;
  assign target = jump_reg ? jr_pc
                : jump_target ? {pc4[31:28], instr_q[25:0], 2'b00}
                : pc4 + {branch_imm[29:0], 2'b00};
  // An instruction enters ID either straight from memory or from the hold buffer.
  assign load = id_accept & (((state_q == S_WAIT) & imem_ack) | (state_q == S_HOLD));
  // The delay slot is always the fetch in flight when a jump resolves, so a redirect
  // only ever steers the address issued after the delay slot loads.
  assign next_addr = take ? target : pend_v_q ? pend_q : addr_q + 32'd4;
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    addr_d = addr_q;
    hold_d = hold_q;
    pc_d = pc_q;
    instr_d = id_accept ? 32'd0 : instr_q;
    valid_d = id_accept ? 1'b0 : valid_q;
    pend_v_d = pend_v_q;
    pend_d = pend_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        req_d = 1'b1;
      end
      S_WAIT: if (imem_ack) begin
        if (id_accept) addr_d = next_addr;
        else begin
          hold_d = imem_rdata;
          req_d = 1'b0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (id_accept) begin
        req_d = 1'b1;
        addr_d = next_addr;
        state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      pc_d = addr_q;
      instr_d = (state_q == S_HOLD) ? hold_q : imem_rdata;
      valid_d = 1'b1;
      pend_v_d = 1'b0;
    end else if (take) begin
      pend_v_d = 1'b1;
      pend_d = target;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q <= 1'b0;
      addr_q <= RESET_PC;
      pc_q <= 32'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      hold_q <= 32'd0;
      pend_v_q <= 1'b0;
      pend_q <= 32'd0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      addr_q <= addr_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      hold_q <= hold_d;
      pend_v_q <= pend_v_d;
      pend_q <= pend_d;
    end
  end
  assign imem_req = req_q;
  assign imem_addr = addr_q;
  assign pc_id = pc_q;
  assign instr_id = instr_q;
  assign valid_id = valid_q;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_q, wait_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= 32'd0;
      wait_q <= 32'd0;
    end else begin
      fetch_q <= fetch_q + {31'd0, req_q & imem_ack};
      wait_q <= wait_q + {31'd0, req_q & ~imem_ack};
    end
  end
  assign perf_fetch_count = fetch_q;
  assign perf_wait_count = wait_q;
`else
  assign perf_fetch_count = 32'd0;
  assign perf_wait_count = 32'd0;
`endif
endmodule
